cic_rate_controller: RTL
========================

// Module: cic_rate_controller
// PURPOSE
//  Sequences the shared cic_decimator: accepts runtime decimation-rate requests and flushes the CIC on every change.
//  Gates the upstream sample stream during the flush, then discards the transient outputs that follow.
//  Forwards settled CIC outputs downstream, with the gain shift for the active rate.
//  Sits between the DDC mixer output and the CIC, with the CIC output fed back through it to the FIR stage.
// PARAMETERS
//  DATA_WIDTH      32  sample width in both directions
//  STAGES          3   CIC order; gain_shift = STAGES*dec_log2
//  MAX_DEC_LOG2    6   largest legal log2(decimation) (R=64)
//  FLUSH_CYCLES    4   cycles cic_rst_n is held low per reconfiguration
//  SETTLE_OUTPUTS  3   CIC outputs discarded after a flush
// PORTS
//  clk             in   1   system clock (100 MHz)
//  rst_n           in   1   asynchronous active-low reset
//  cfg_dec_log2    in   3   requested log2(decimation)
//  cfg_valid       in   1   config request; accepted when cfg_valid & cfg_ready
//  cfg_ready       out  1   high in IDLE, SETTLE and RUN; low in FLUSH
//  cfg_err         out  1   1-cycle pulse: request had cfg_dec_log2==0 or >MAX_DEC_LOG2
//  s_data          in   DW  upstream sample
//  s_valid         in   1   upstream sample valid
//  s_ready         out  1   high in SETTLE and RUN only
//  cic_rst_n       out  1   synchronous clear to the CIC, active low
//  cic_data_in     out  DW  = s_data (combinational)
//  cic_data_valid  out  1   = s_valid & s_ready (combinational)
//  cic_dec_log2    out  3   active rate, registered
//  cic_data_out    in   DW  CIC output sample
//  cic_output_valid in  1   CIC output strobe
//  m_data          out  DW  forwarded sample, registered
//  m_valid         out  1   forwarded strobe, registered; no backpressure
//  gain_shift      out  5   STAGES*cic_dec_log2, registered
//  locked          out  1   high in RUN only
//  out_count       out  16  settled outputs since last accept; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset values: state=IDLE, all outputs 0, including cic_rst_n=0, cfg_ready=0 and s_ready=0.
//  IDLE: CIC held in clear (cic_rst_n=0); cfg_ready=1 from the first clk after reset deasserts.
//  Valid accept (any state with cfg_ready=1):
//    cic_dec_log2 and gain_shift update on the next clk; the flush counter loads FLUSH_CYCLES-1.
//    The discard counter loads SETTLE_OUTPUTS; out_count clears to 0.
//    State goes to FLUSH.
//  Invalid accept: cfg_err=1 for one cycle; state, rate and counters unchanged.
//  FLUSH: cic_rst_n=0 and s_ready=0 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
//  SETTLE: s_ready=1 and cic_rst_n=1.
//    Each cic_output_valid decrements the discard counter; m_valid stays 0.
//    The cycle that consumes the last discard moves to RUN. SETTLE_OUTPUTS=0 moves straight to RUN.
//  RUN: each cic_output_valid gives m_data<=cic_data_out and m_valid<=1 on the next clk; out_count increments.
//    Latency from cic_output_valid to m_valid is 1 cycle.
//  cfg accept in the same cycle as cic_output_valid in RUN: that output is still forwarded (old rate).
//    All outputs after it are discarded per SETTLE.
//  cic_output_valid in IDLE or FLUSH is ignored.
//  rst_n low mid-operation: everything returns to its reset value immediately; an in-flight m_valid is dropped.
//  gain_shift arithmetic: 3x3-bit product, width 5 (max 3*6=18).
// STRUCTURE
//  Shared package cic_ctrl_pkg:
//    state enum {IDLE, FLUSH, SETTLE, RUN};
//    function gain_shift_f(dec_log2, stages);
//    constants for the FLUSH_CYCLES and SETTLE_OUTPUTS defaults.
//  Single flat module: one FSM plus three counters (flush, discard, out_count). No sub-module.
// TESTING
//  1 reset release -> cic_rst_n=0, cfg_ready=1, s_ready=0, locked=0, m_valid never asserts.
//  2 cfg_dec_log2=3 accept -> cic_dec_log2=3, gain_shift=9, cic_rst_n low 4 cycles.
//    Then 64 samples give 8 CIC outputs: first 3 discarded, 5 forwarded, out_count=5.
//  3 cfg_dec_log2=0 and then 7 -> cfg_err pulses twice; rate stays 3; locked unchanged.
//  4 reconfigure to dec_log2=6 in the same cycle as cic_output_valid in RUN.
//    -> that sample appears on m_data; gain_shift=18; out_count=0; no forwarding until 3 discards.
//  5 s_valid held high through FLUSH -> cic_data_valid=0 for all 4 flush cycles; no sample reaches the CIC.
//  6 rst_n pulsed low in RUN with m_valid due next cycle -> m_valid stays 0; state IDLE; all outputs at reset values.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared types, defaults and helpers for the CIC rate controller.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int STAGES_DEF         = 3;
    localparam int MAX_DEC_LOG2_DEF   = 6;
    localparam int FLUSH_CYCLES_DEF   = 4;
    localparam int SETTLE_OUTPUTS_DEF = 3;

    // CIC gain is R^N, so the compensating shift is N*log2(R); 3x3-bit product fits in 5 bits for legal rates.
    function automatic logic [4:0] gain_shift_f(input logic [2:0] dec_log2, input logic [2:0] stages);
        logic [5:0] prod;
        prod = {3'b000, dec_log2} * {3'b000, stages};
        return prod[4:0];
    endfunction

endpackage

// File: rtl/cic_rate_controller.sv
// Sequences the shared CIC decimator: rate changes flush it, transient outputs are dropped,
// settled outputs are forwarded downstream with the matching gain shift.
module cic_rate_controller
    import cic_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int STAGES         = STAGES_DEF,
    parameter int MAX_DEC_LOG2   = MAX_DEC_LOG2_DEF,
    parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
    parameter int SETTLE_OUTPUTS = SETTLE_OUTPUTS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            cfg_dec_log2,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  cic_rst_n,
    output logic [DATA_WIDTH-1:0] cic_data_in,
    output logic                  cic_data_valid,
    output logic [2:0]            cic_dec_log2,
    input  logic [DATA_WIDTH-1:0] cic_data_out,
    input  logic                  cic_output_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic [4:0]            gain_shift,
    output logic                  locked,
    output logic [15:0]           out_count
);

    localparam logic [2:0] MAX_RATE   = 3'(MAX_DEC_LOG2);
    localparam logic [2:0] STAGES_W   = 3'(STAGES);
    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] DISC_LOAD  = 8'(SETTLE_OUTPUTS);

    state_t     state, state_nxt;
    logic       ready_en;
    logic [7:0] flush_cnt;
    logic [7:0] disc_cnt;
    logic       accept;
    logic       rate_ok;
    logic       good_acc;
    logic       bad_acc;
    logic       run_out;

    // cfg_ready stays low during the reset cycle itself and rises on the first clk afterwards.
    assign cfg_ready      = ready_en && (state != FLUSH);
    assign s_ready        = (state == SETTLE) || (state == RUN);
    assign cic_rst_n      = s_ready;
    assign locked         = (state == RUN);
    assign cic_data_in    = s_data;
    assign cic_data_valid = s_valid && s_ready;

    assign accept   = cfg_valid && cfg_ready;
    assign rate_ok  = (cfg_dec_log2 != 3'd0) && (cfg_dec_log2 <= MAX_RATE);
    assign good_acc = accept && rate_ok;
    assign bad_acc  = accept && !rate_ok;
    assign run_out  = (state == RUN) && cic_output_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = IDLE;
            FLUSH:  if (flush_cnt == 8'd0)
                        state_nxt = (DISC_LOAD == 8'd0) ? RUN : SETTLE;
            SETTLE: if ((disc_cnt == 8'd0) || (cic_output_valid && (disc_cnt == 8'd1)))
                        state_nxt = RUN;
            RUN:    state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        // A new rate always restarts the flush, whatever stage of settling we were in.
        if (good_acc)
            state_nxt = FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cic_dec_log2 <= 3'd0;
            gain_shift   <= 5'd0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err <= bad_acc;
            if (good_acc) begin
                cic_dec_log2 <= cfg_dec_log2;
                gain_shift   <= gain_shift_f(cfg_dec_log2, STAGES_W);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= 8'd0;
            disc_cnt  <= 8'd0;
            out_count <= 16'd0;
        end else if (good_acc) begin
            flush_cnt <= FLUSH_LOAD;
            disc_cnt  <= DISC_LOAD;
            out_count <= 16'd0;
        end else begin
            if ((state == FLUSH) && (flush_cnt != 8'd0))
                flush_cnt <= flush_cnt - 8'd1;
            if ((state == SETTLE) && cic_output_valid && (disc_cnt != 8'd0))
                disc_cnt <= disc_cnt - 8'd1;
            if (run_out)
                out_count <= out_count + 16'd1;
        end
    end

    // An output coinciding with a reconfigure was produced at the old rate and is still valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= run_out;
            if (run_out)
                m_data <= cic_data_out;
        end
    end

endmodule
